mul_share_ctrl: RTL and testbench



---
 rtl/mul_pkg.sv | 11 +
 rtl/mul_share_ctrl_if.sv | 43 ++++
 rtl/mul_rr_arbiter.sv | 27 ++
 rtl/mul_share_ctrl.sv | 110 +++++++++++
 tb/tb_mul_share_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mul_pkg.sv
// mul_pkg: shared widths, controller state encoding and id-width helper
package mul_pkg;
    localparam int WIDTH     = 8;
    localparam int OUT_WIDTH = 2 * WIDTH;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/mul_share_ctrl_if.sv
// mul_share_ctrl_if: requester/response bundle and multiplier-core bundle
interface mul_req_if #(
    parameter int WIDTH = mul_pkg::WIDTH,
    parameter int NREQ  = 4
);
    logic [NREQ-1:0]                req_valid;
    logic [NREQ*WIDTH-1:0]          req_a;
    logic [NREQ*WIDTH-1:0]          req_b;
    logic [NREQ-1:0]                req_ready;
    logic                           resp_valid;
    logic                           resp_ready;
    logic [mul_pkg::id_w(NREQ)-1:0] resp_id;
    logic [2*WIDTH-1:0]             resp_o;

    modport master (
        output req_valid, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_o
    );
    modport slave (
        input  req_valid, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_id, resp_o
    );
endinterface

interface mul_core_if #(
    parameter int WIDTH = mul_pkg::WIDTH
);
    logic               mul_in_valid;
    logic [WIDTH-1:0]   mul_a;
    logic [WIDTH-1:0]   mul_b;
    logic               mul_in_ready;
    logic               mul_out_valid;
    logic [2*WIDTH-1:0] mul_o;

    modport master (
        output mul_in_valid, mul_a, mul_b,
        input  mul_in_ready, mul_out_valid, mul_o
    );
    modport slave (
        input  mul_in_valid, mul_a, mul_b,
        output mul_in_ready, mul_out_valid, mul_o
    );
endinterface

// File: rtl/mul_rr_arbiter.sv
// mul_rr_arbiter: combinational round-robin pick starting at ptr
module mul_rr_arbiter
    import mul_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = id_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx,
    output logic            any
);
    logic [NREQ-1:0] rot;
    logic [IW:0]     sum;

    // Rotate so bit 0 is the pointer slot; the lowest set bit of the rotated vector wins
    always_comb begin
        rot = NREQ'({req, req} >> ptr);
        sum = '0;
        for (int k = NREQ - 1; k >= 0; k--)
            if (rot[k]) sum = {1'b0, ptr} + (IW+1)'(k);
        idx = (sum >= (IW+1)'(NREQ)) ? IW'(sum - (IW+1)'(NREQ)) : IW'(sum);
        any = |req;
        gnt = any ? (NREQ'(1) << idx) : '0;
    end
endmodule

// File: rtl/mul_share_ctrl.sv
// mul_share_ctrl: round-robin sharing of one multiplier core with tagged responses and watchdog
module mul_share_ctrl
    import mul_pkg::*;
#(
    parameter int WIDTH   = mul_pkg::WIDTH,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 2 * WIDTH + 4
) (
    input  logic       clk,
    input  logic       rst_n,
    mul_req_if.slave   req,
    mul_core_if.master core,
    output logic       timeout_err,
    output logic       spurious_err
);
    localparam int IW = id_w(NREQ);
    localparam int OW = 2 * WIDTH;
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t          state_q, state_d;
    logic [IW-1:0]   rr_q, rr_d, id_q, id_d, gnt_idx;
    logic [OW-1:0]   res_q, res_d;
    logic [TW-1:0]   wdog_q, wdog_d;
    logic            tout_q, tout_d, spur_q, spur_d;
    logic [NREQ-1:0] gnt;
    logic            any, issue, resp_v;
    logic [WIDTH-1:0] sel_a, sel_b;

    mul_rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req (req.req_valid),
        .ptr (rr_q),
        .gnt (gnt),
        .idx (gnt_idx),
        .any (any)
    );

    // Issue only from IDLE with an idle core; response fields are zero outside RESP
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NREQ; i++)
            if (gnt[i]) begin
                sel_a = req.req_a[i*WIDTH +: WIDTH];
                sel_b = req.req_b[i*WIDTH +: WIDTH];
            end
        issue             = (state_q == IDLE) && any && core.mul_in_ready;
        resp_v            = (state_q == RESP);
        core.mul_in_valid = issue;
        core.mul_a        = issue ? sel_a : '0;
        core.mul_b        = issue ? sel_b : '0;
        req.req_ready     = issue ? gnt : '0;
        req.resp_valid    = resp_v;
        req.resp_id       = resp_v ? id_q : '0;
        req.resp_o        = resp_v ? res_q : '0;
    end

    assign timeout_err  = tout_q;
    assign spurious_err = spur_q;

    // Next state, watchdog and capture; finishes in IDLE are stale and dropped silently
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        id_d    = id_q;
        res_d   = res_q;
        wdog_d  = wdog_q;
        tout_d  = tout_q;
        spur_d  = spur_q;
        unique case (state_q)
            IDLE: if (issue) begin
                id_d    = gnt_idx;
                rr_d    = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
                wdog_d  = '0;
                state_d = WAIT;
            end
            WAIT: begin
                wdog_d = (wdog_q == TW'(TIMEOUT)) ? wdog_q : wdog_q + 1'b1;
                if (core.mul_out_valid) begin
                    res_d   = core.mul_o;
                    state_d = RESP;
                end else if (wdog_q == TW'(TIMEOUT - 1)) tout_d = 1'b1;
            end
            RESP: begin
                if (core.mul_out_valid) spur_d = 1'b1;
                if (req.resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and capture registers
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q <= IDLE;
            rr_q    <= '0;
            id_q    <= '0;
            res_q   <= '0;
            wdog_q  <= '0;
            tout_q  <= 1'b0;
            spur_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            id_q    <= id_d;
            res_q   <= res_d;
            wdog_q  <= wdog_d;
            tout_q  <= tout_d;
            spur_q  <= spur_d;
        end
endmodule

// File: tb/tb_mul_share_ctrl.sv
// tb_mul_share_ctrl: directed self-checking bench with a behavioural shift-and-add core
module tb_mul_share_ctrl;
    localparam int W  = 8;
    localparam int N  = 4;
    localparam int TO = 2 * W + 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic timeout_err, spurious_err;

    always #5 clk = ~clk;

    mul_req_if  #(.WIDTH(W), .NREQ(N)) rq ();
    mul_core_if #(.WIDTH(W))           cr ();

    mul_share_ctrl #(.WIDTH(W), .NREQ(N), .TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (rq),
        .core         (cr),
        .timeout_err  (timeout_err),
        .spurious_err (spurious_err)
    );

    int n_chk = 0;
    int n_err = 0;
    int n_iss = 0;
    int i0;

    logic busy = 1'b0;
    logic hang = 1'b0;
    logic kick = 1'b0;
    int   lat  = 4;
    int   cnt  = 0;
    logic [W-1:0] ma = '0;
    logic [W-1:0] mb = '0;

    function automatic logic [2*W-1:0] sa_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] p;
        p = '0;
        for (int i = 0; i < W; i++)
            if (b[i]) p = p + ({{W{1'b0}}, a} << i);
        return p;
    endfunction

    assign cr.mul_in_ready = !busy;

    // Core model: zero operand finishes 2 cycles after issue, others after lat; hang waits for kick
    always @(posedge clk) begin
        cr.mul_out_valid <= 1'b0;
        cr.mul_o         <= '0;
        if (kick) begin
            cr.mul_out_valid <= 1'b1;
            cr.mul_o         <= busy ? sa_mul(ma, mb) : 16'hDEAD;
            busy             <= 1'b0;
        end else if (busy && !hang && cnt == 1) begin
            cr.mul_out_valid <= 1'b1;
            cr.mul_o         <= sa_mul(ma, mb);
            busy             <= 1'b0;
        end else if (busy && !hang) cnt <= cnt - 1;
        if (!busy && cr.mul_in_valid) begin
            busy <= 1'b1;
            ma   <= cr.mul_a;
            mb   <= cr.mul_b;
            cnt  <= (cr.mul_a == 0 || cr.mul_b == 0) ? 1 : lat - 1;
        end
    end

    always @(posedge clk) if (cr.mul_in_valid) n_iss <= n_iss + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        rq.req_valid[i]     = 1'b1;
        rq.req_a[i*W +: W]  = a;
        rq.req_b[i*W +: W]  = b;
    endtask

    task automatic wait_issue(input string tag);
        #1;
        for (int i = 0; i < 60 && !cr.mul_in_valid; i++) step();
        chk({tag, "_issue"}, 32'(cr.mul_in_valid), 1);
    endtask

    task automatic wait_resp(input string tag);
        #1;
        for (int i = 0; i < 60 && !rq.resp_valid; i++) step();
        chk({tag, "_resp"}, 32'(rq.resp_valid), 1);
    endtask

    int eid[5] = '{0, 1, 2, 3, 0};
    int ea[5]  = '{1, 2, 3, 4, 10};
    int eo[5]  = '{2, 4, 6, 8, 30};

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rq.req_valid  = '0;
        rq.req_a      = '0;
        rq.req_b      = '0;
        rq.resp_ready = 1'b0;
        #13;
        chk("rst_resp_valid", 32'(rq.resp_valid), 0);
        chk("rst_resp_o", 32'(rq.resp_o), 0);
        chk("rst_req_ready", 32'(rq.req_ready), 0);
        chk("rst_in_valid", 32'(cr.mul_in_valid), 0);
        chk("rst_errs", {30'd0, timeout_err, spurious_err}, 0);
        @(negedge clk) rst_n = 1'b1;
        step();

        // single request
        set_req(0, 3, 5);
        rq.resp_ready = 1'b1;
        #1;
        i0 = n_iss;
        chk("single_in_valid", 32'(cr.mul_in_valid), 1);
        chk("single_a", 32'(cr.mul_a), 3);
        chk("single_b", 32'(cr.mul_b), 5);
        chk("single_ready", 32'(rq.req_ready), 1);
        step();
        rq.req_valid = '0;
        #1;
        chk("single_in_valid_off", 32'(cr.mul_in_valid), 0);
        chk("single_ready_off", 32'(rq.req_ready), 0);
        wait_resp("single");
        chk("single_id", 32'(rq.resp_id), 0);
        chk("single_o", 32'(rq.resp_o), 15);
        chk("single_pulses", 32'(n_iss - i0), 1);
        step();
        chk("single_resp_done", 32'(rq.resp_valid), 0);

        // fresh pointer, then contention with re-raise of requester 0
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        step();
        for (int i = 0; i < N; i++) set_req(i, W'(i + 1), 2);
        for (int k = 0; k < 5; k++) begin
            wait_issue("cont");
            chk("cont_gnt", 32'(rq.req_ready), 32'(1) << eid[k]);
            chk("cont_a", 32'(cr.mul_a), 32'(ea[k]));
            step();
            rq.req_valid[eid[k]] = 1'b0;
            wait_resp("cont");
            chk("cont_id", 32'(rq.resp_id), 32'(eid[k]));
            chk("cont_o", 32'(rq.resp_o), 32'(eo[k]));
            if (k == 0) set_req(0, 10, 3);
            step();
        end

        // backpressure with a competing request held off until handshake
        rq.resp_ready = 1'b0;
        set_req(2, 7, 9);
        wait_issue("bp");
        step();
        rq.req_valid[2] = 1'b0;
        wait_resp("bp");
        set_req(3, 1, 1);
        i0 = n_iss;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_valid", 32'(rq.resp_valid), 1);
            chk("bp_id", 32'(rq.resp_id), 2);
            chk("bp_o", 32'(rq.resp_o), 63);
            chk("bp_no_issue", 32'(cr.mul_in_valid), 0);
            step();
        end
        rq.resp_ready = 1'b1;
        step();
        #1;
        chk("bp_next_issue", 32'(cr.mul_in_valid), 1);
        chk("bp_next_gnt", 32'(rq.req_ready), 8);
        chk("bp_pulses", 32'(n_iss - i0), 0);
        step();
        rq.req_valid[3] = 1'b0;
        wait_resp("bp2");
        chk("bp2_o", 32'(rq.resp_o), 1);
        step();

        // zero operand: finish at issue+2, resp_valid at issue+3
        set_req(0, 0, 200);
        #1;
        chk("zero_issue", 32'(cr.mul_in_valid), 1);
        step();
        rq.req_valid[0] = 1'b0;
        #1;
        chk("zero_t1_resp", 32'(rq.resp_valid), 0);
        step();
        chk("zero_t2_finish", 32'(cr.mul_out_valid), 1);
        chk("zero_t2_resp", 32'(rq.resp_valid), 0);
        step();
        chk("zero_t3_resp", 32'(rq.resp_valid), 1);
        chk("zero_o", 32'(rq.resp_o), 0);
        step();

        // maximum operands
        set_req(1, 255, 255);
        wait_issue("max");
        step();
        rq.req_valid[1] = 1'b0;
        wait_resp("max");
        chk("max_id", 32'(rq.resp_id), 1);
        chk("max_o", 32'(rq.resp_o), 65025);
        step();

        // watchdog: the core hangs until kicked
        hang = 1'b1;
        set_req(2, 6, 7);
        #1;
        chk("wd_issue", 32'(cr.mul_in_valid), 1);
        step();
        rq.req_valid[2] = 1'b0;
        for (int i = 0; i < TO - 2; i++) step();
        chk("wd_before", 32'(timeout_err), 0);
        step();
        step();
        chk("wd_set", 32'(timeout_err), 1);
        for (int i = 0; i < 5; i++) step();
        chk("wd_sticky", 32'(timeout_err), 1);
        chk("wd_no_resp", 32'(rq.resp_valid), 0);
        kick = 1'b1;
        step();
        kick = 1'b0;
        hang = 1'b0;
        step();
        chk("wd_late_resp", 32'(rq.resp_valid), 1);
        chk("wd_late_id", 32'(rq.resp_id), 2);
        chk("wd_late_o", 32'(rq.resp_o), 42);
        step();

        // reset while waiting, then a stale finish from the un-reset core
        lat = 8;
        set_req(2, 2, 3);
        wait_issue("rw");
        step();
        rq.req_valid[2] = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        chk("rw_resp_valid", 32'(rq.resp_valid), 0);
        chk("rw_resp_id", 32'(rq.resp_id), 0);
        chk("rw_resp_o", 32'(rq.resp_o), 0);
        chk("rw_in_valid", 32'(cr.mul_in_valid), 0);
        chk("rw_a", 32'(cr.mul_a), 0);
        chk("rw_timeout", 32'(timeout_err), 0);
        rst_n = 1'b1;
        for (int i = 0; i < 30 && !cr.mul_out_valid; i++) step();
        chk("rw_stale_seen", 32'(cr.mul_out_valid), 1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rw_no_resp", 32'(rq.resp_valid), 0);
            chk("rw_no_spur", 32'(spurious_err), 0);
        end
        set_req(0, 5, 5);
        set_req(3, 6, 6);
        wait_issue("rw_ptr");
        chk("rw_ptr_gnt", 32'(rq.req_ready), 1);
        step();
        rq.req_valid[0] = 1'b0;
        wait_resp("rw_a");
        chk("rw_a_o", 32'(rq.resp_o), 25);
        step();
        wait_issue("rw_b");
        chk("rw_b_gnt", 32'(rq.req_ready), 8);
        step();
        rq.req_valid[3] = 1'b0;
        wait_resp("rw_b");
        chk("rw_b_o", 32'(rq.resp_o), 36);
        step();

        // extra finish while a response is pending
        rq.resp_ready = 1'b0;
        set_req(1, 4, 4);
        wait_issue("sp");
        step();
        rq.req_valid[1] = 1'b0;
        wait_resp("sp");
        kick = 1'b1;
        step();
        kick = 1'b0;
        chk("sp_not_yet", 32'(spurious_err), 0);
        step();
        chk("sp_set", 32'(spurious_err), 1);
        chk("sp_resp_held", 32'(rq.resp_valid), 1);
        chk("sp_id", 32'(rq.resp_id), 1);
        chk("sp_o", 32'(rq.resp_o), 16);
        rq.resp_ready = 1'b1;
        step();
        chk("sp_resp_done", 32'(rq.resp_valid), 0);
        chk("sp_sticky", 32'(spurious_err), 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
